univ_reg_n: RTL and testbench



---
 rtl/univ_reg_n.sv | 129 ++++++++++++
 tb/tb_univ_reg_n.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/univ_reg_n.sv
// univ_reg_n: WIDTH-bit universal register with load, shift, rotate,
// increment and decrement modes, plus registered carry and zero flags.
// Serves as accumulator, program counter and shift register in the 8-bit
// Harvard datapath. All state changes on the rising edge of clock, and
// every output comes straight from a flop.
//
// mode | operation
// 000  | HOLD  q and carry unchanged
// 001  | LOAD  q <= d, carry <= 0
// 010  | SHL   shift left, ser_in enters at bit 0, carry <= old msb
// 011  | SHR   shift right, ser_in enters at msb, carry <= old lsb
// 100  | ROL   rotate left, carry <= old msb
// 101  | ROR   rotate right, carry <= old lsb
// 110  | INC   q + 1 mod 2^WIDTH, carry <= old q was all ones
// 111  | DEC   q - 1 mod 2^WIDTH, carry <= old q was zero

module univ_reg_n #(
    parameter int unsigned         WIDTH     = 8,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] L_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic             r_zero;

    logic [WIDTH-1:0] w_next_q;
    logic             w_next_carry;
    logic             w_msb;
    logic             w_lsb;
    logic             w_all_ones;
    logic             w_is_zero;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;

    assign w_msb      = r_q[WIDTH-1];
    assign w_lsb      = r_q[0];
    assign w_all_ones = &r_q;
    assign w_is_zero  = ~|r_q;

    // Truncated WIDTH-bit arithmetic; the carry/borrow comes from the old
    // value's wrap condition rather than from a widened adder.
    assign w_inc = r_q + L_ONE;
    assign w_dec = r_q - L_ONE;

    // Next-state selection for q and carry; en=0 behaves exactly like HOLD.
    always_comb begin
        w_next_q     = r_q;
        w_next_carry = r_carry;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    w_next_q     = r_q;
                    w_next_carry = r_carry;
                end
                MODE_LOAD: begin
                    w_next_q     = d;
                    w_next_carry = 1'b0;
                end
                MODE_SHL: begin
                    w_next_q     = {r_q[WIDTH-2:0], ser_in};
                    w_next_carry = w_msb;
                end
                MODE_SHR: begin
                    w_next_q     = {ser_in, r_q[WIDTH-1:1]};
                    w_next_carry = w_lsb;
                end
                MODE_ROL: begin
                    w_next_q     = {r_q[WIDTH-2:0], w_msb};
                    w_next_carry = w_msb;
                end
                MODE_ROR: begin
                    w_next_q     = {w_lsb, r_q[WIDTH-1:1]};
                    w_next_carry = w_lsb;
                end
                MODE_INC: begin
                    w_next_q     = w_inc;
                    w_next_carry = w_all_ones;
                end
                MODE_DEC: begin
                    w_next_q     = w_dec;
                    w_next_carry = w_is_zero;
                end
                default: begin
                    w_next_q     = r_q;
                    w_next_carry = r_carry;
                end
            endcase
        end
    end

    // State register; zero is always derived from the value q is about to take.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q     <= RESET_VAL;
            r_carry <= 1'b0;
            r_zero  <= (RESET_VAL == '0);
        end else begin
            r_q     <= w_next_q;
            r_carry <= w_next_carry;
            r_zero  <= (w_next_q == '0);
        end
    end

    assign q     = r_q;
    assign carry = r_carry;
    assign zero  = r_zero;

endmodule

// File: tb/tb_univ_reg_n.sv
// Scoreboard bench for univ_reg_n: two instances (8-bit/reset 0 and
// 4-bit/reset 9) share one stimulus stream. An arithmetic reference model
// pushes expected results into a queue; a monitor pops and compares.

module tb_univ_reg_n;

    logic       clock;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d8;
    logic [3:0] d4;
    logic       ser_in;

    logic [7:0] q8;
    logic       carry8, zero8;
    logic [3:0] q4;
    logic       carry4, zero4;

    int passed;
    int total;

    typedef struct {
        int q8;
        int c8;
        int q4;
        int c4;
        int idx;
    } exp_t;

    exp_t sb[$];

    int m8_q, m8_c, m4_q, m4_c;
    int step_idx;

    assign d4 = d8[3:0];

    univ_reg_n #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut8 (
        .clock(clock), .reset(reset), .en(en), .mode(mode),
        .d(d8), .ser_in(ser_in), .q(q8), .carry(carry8), .zero(zero8)
    );

    univ_reg_n #(.WIDTH(4), .RESET_VAL(4'h9)) u_dut4 (
        .clock(clock), .reset(reset), .en(en), .mode(mode),
        .d(d4), .ser_in(ser_in), .q(q4), .carry(carry4), .zero(zero4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: the register as an unsigned number modulo 2^w.
    function automatic void model(input int w, input int rv, input int qm, input int cm,
                                  input bit rst, input bit e, input int md, input int dv,
                                  input bit s, output int nq, output int nc);
        int m, top;
        m   = 1 << w;
        top = 1 << (w - 1);
        nq  = qm;
        nc  = cm;
        if (rst) begin
            nq = rv;
            nc = 0;
        end else if (e) begin
            case (md)
                0: begin nq = qm; nc = cm; end
                1: begin nq = dv % m; nc = 0; end
                2: begin nq = (qm * 2 + int'(s)) % m; nc = (qm >= top) ? 1 : 0; end
                3: begin nq = qm / 2 + int'(s) * top; nc = qm % 2; end
                4: begin nq = (qm * 2) % m + ((qm >= top) ? 1 : 0); nc = (qm >= top) ? 1 : 0; end
                5: begin nq = qm / 2 + (qm % 2) * top; nc = qm % 2; end
                6: begin nq = (qm + 1) % m; nc = (qm == m - 1) ? 1 : 0; end
                default: begin nq = (qm + m - 1) % m; nc = (qm == 0) ? 1 : 0; end
            endcase
        end
    endfunction

    task automatic step(input bit rst, input bit e, input int md, input int dv, input bit s);
        exp_t x;
        int nq, nc;
        reset  = rst;
        en     = e;
        mode   = md[2:0];
        d8     = dv[7:0];
        ser_in = s;
        @(posedge clock);
        model(8, 0, m8_q, m8_c, rst, e, md, dv, s, nq, nc);
        m8_q = nq; m8_c = nc;
        model(4, 9, m4_q, m4_c, rst, e, md, dv, s, nq, nc);
        m4_q = nq; m4_c = nc;
        x.q8 = m8_q; x.c8 = m8_c; x.q4 = m4_q; x.c4 = m4_c; x.idx = step_idx;
        sb.push_back(x);
        step_idx++;
        @(negedge clock);
    endtask

    task automatic check_bit(input string name, input int idx, input logic act, input int exp);
        total++;
        if (act === exp[0]) passed++;
        else $display("FAIL %s step %0d: got %b expected %0d", name, idx, act, exp);
    endtask

    // Monitor: every cycle after a stimulus edge the DUT presents a result.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                total++;
                if (q8 === x.q8[7:0]) passed++;
                else $display("FAIL q8 step %0d: got %h expected %h", x.idx, q8, x.q8[7:0]);
                check_bit("carry8", x.idx, carry8, x.c8);
                check_bit("zero8", x.idx, zero8, (x.q8 == 0) ? 1 : 0);
                total++;
                if (q4 === x.q4[3:0]) passed++;
                else $display("FAIL q4 step %0d: got %h expected %h", x.idx, q4, x.q4[3:0]);
                check_bit("carry4", x.idx, carry4, x.c4);
                check_bit("zero4", x.idx, zero4, (x.q4 == 0) ? 1 : 0);
            end
        end
    end

    initial begin
        passed = 0; total = 0; step_idx = 0;
        m8_q = 0; m8_c = 0; m4_q = 0; m4_c = 0;
        reset = 1'b0; en = 1'b0; mode = 3'd0; d8 = 8'h00; ser_in = 1'b0;
        @(negedge clock);

        // Reset and load
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 'hA5, 0);
        // Shift with serial input, then hold with en=0
        step(0, 1, 2, 'h00, 1);
        step(0, 1, 3, 'hFF, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 2, 'h3C, 1);
        // Rotate
        step(0, 1, 1, 'h81, 0);
        step(0, 1, 4, 0, 1);
        step(0, 1, 5, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 4, 'hFF, i[0]);
        // Increment wrap (also takes the 4-bit copy through F -> 0)
        step(0, 1, 1, 'hFE, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 6, 0, 0);
        step(0, 1, 1, 'h0F, 0);
        step(0, 1, 6, 0, 0);
        // Decrement borrow
        step(0, 1, 1, 'h01, 0);
        step(0, 1, 7, 0, 0);
        step(0, 1, 7, 0, 0);
        // Reset mid-count: no partial increment on the reset edge
        step(0, 1, 1, 'h10, 0);
        step(0, 1, 6, 0, 0);
        step(0, 1, 6, 0, 0);
        step(1, 1, 6, 'h55, 1);
        step(0, 1, 6, 0, 0);
        // Explicit HOLD mode with en=1
        step(0, 1, 0, 'hAA, 1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 $urandom_range(0, 1) == 1);
        end

        // Bounded drain of the scoreboard
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
